// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg -- shared definitions for the instruction fetch unit.
//   * IFU_Ctrl next-PC select encodings (NPC_*)
//   * FSM state encoding (ST_*)
//   * default reset PC
//   * branch_offset(): sign-extends a 16-bit branch offset and scales it by 4
// -----------------------------------------------------------------------------
package ifu_pkg;

    // Next-PC select encodings carried on IFU_Ctrl
    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // PC loaded on reset unless the instance overrides it
    localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h0000_3000;

    // Word offset of a branch: sign-extend and multiply by 4
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_if.sv
// -----------------------------------------------------------------------------
// ifu_if -- bundle of the IFU control, memory and instruction-out signals.
//   master : the fetch unit side (drives request + instruction outputs)
//   slave  : the environment side (memory, decode/consumer)
// Signals:
//   IFU_Ctrl/Imm16/Imm26/RegAddr : resolved next-PC select and operands
//   IFU_Next                     : consumer accepts the held instruction
//   IFU_ImemReq/ImemAddr         : fetch request
//   IFU_ImemValid/ImemRdata      : fetch response
//   IFU_Instr/InstrValid/PC/PCPlus4 : fetched instruction and its address
//   IFU_AddrErr                  : bad fetch address flag
// -----------------------------------------------------------------------------
interface ifu_if;
    logic [1:0]  IFU_Ctrl;
    logic [15:0] IFU_Imm16;
    logic [25:0] IFU_Imm26;
    logic [31:0] IFU_RegAddr;
    logic        IFU_Next;
    logic        IFU_ImemReq;
    logic [31:0] IFU_ImemAddr;
    logic        IFU_ImemValid;
    logic [31:0] IFU_ImemRdata;
    logic [31:0] IFU_Instr;
    logic        IFU_InstrValid;
    logic [31:0] IFU_PC;
    logic [31:0] IFU_PCPlus4;
    logic        IFU_AddrErr;

    modport master (
        input  IFU_Ctrl, IFU_Imm16, IFU_Imm26, IFU_RegAddr, IFU_Next,
        input  IFU_ImemValid, IFU_ImemRdata,
        output IFU_ImemReq, IFU_ImemAddr,
        output IFU_Instr, IFU_InstrValid, IFU_PC, IFU_PCPlus4, IFU_AddrErr
    );

    modport slave (
        output IFU_Ctrl, IFU_Imm16, IFU_Imm26, IFU_RegAddr, IFU_Next,
        output IFU_ImemValid, IFU_ImemRdata,
        input  IFU_ImemReq, IFU_ImemAddr,
        input  IFU_Instr, IFU_InstrValid, IFU_PC, IFU_PCPlus4, IFU_AddrErr
    );
endinterface

// File: rtl/ifu_npc.sv
// -----------------------------------------------------------------------------
// ifu_npc -- combinational next-PC calculation.
//   pc_i        : current PC
//   ctrl_i      : next-PC select (NPC_*)
//   imm16_i     : branch offset (words, signed)
//   imm26_i     : jump index
//   reg_addr_i  : jump-register target
//   pc_plus4_o  : pc_i + 4 (mod 2^32)
//   npc_o       : selected next PC
// -----------------------------------------------------------------------------
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  ctrl_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] reg_addr_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] npc_o
);

    logic [31:0] seq_s;

    assign seq_s      = pc_i + 32'd4;
    assign pc_plus4_o = seq_s;

    // Next-PC select; branch and jump are both relative to the sequential PC
    always_comb begin
        npc_o = seq_s;
        case (ctrl_i)
            NPC_PLUS4:  npc_o = seq_s;
            NPC_BRANCH: npc_o = seq_s + branch_offset(imm16_i);
            NPC_JUMP:   npc_o = {seq_s[31:28], imm26_i, 2'b00};
            NPC_JR:     npc_o = reg_addr_i;
            default:    npc_o = seq_s;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu -- instruction fetch unit: FETCH -> WAIT -> READY per instruction.
// Ports:
//   IFU_Clk      : clock, rising edge
//   IFU_Reset_n  : asynchronous active-low reset
//   bus          : ifu_if.master (control in, memory request/response,
//                  instruction/PC out, address error flag)
// Parameters:
//   RESET_PC     : PC after reset
//   IMEM_WORDS   : instruction memory size in words (range check only)
// Build option:
//   IFU_ADDR_CHECK_EN : when defined, a misaligned or out-of-range PC
//                       suppresses the fetch and sets a sticky IFU_AddrErr.
// -----------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 1024
)(
    input  logic  IFU_Clk,
    input  logic  IFU_Reset_n,
    ifu_if.master bus
);

    // End of the fetchable window, one bit wider so it cannot wrap
    localparam logic [32:0] PC_END = {1'b0, RESET_PC} + (33'(IMEM_WORDS) * 33'd4);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] npc_s;
    logic [31:0] pc_plus4_s;
    logic        addr_bad_s;
    logic        fetch_block_s;

    ifu_npc u_npc (
        .pc_i       (pc_q),
        .ctrl_i     (bus.IFU_Ctrl),
        .imm16_i    (bus.IFU_Imm16),
        .imm26_i    (bus.IFU_Imm26),
        .reg_addr_i (bus.IFU_RegAddr),
        .pc_plus4_o (pc_plus4_s),
        .npc_o      (npc_s)
    );

    assign addr_bad_s = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) ||
                        ({1'b0, pc_q} >= PC_END);

`ifdef IFU_ADDR_CHECK_EN
    // Once flagged, the FSM is parked in FETCH with the request suppressed
    assign fetch_block_s   = addr_bad_s || addr_err_q;
    assign bus.IFU_AddrErr = addr_err_q;
`else
    logic unused_s;
    assign fetch_block_s   = 1'b0;
    assign bus.IFU_AddrErr = 1'b0;
    assign unused_s        = addr_bad_s ^ addr_err_q;
`endif

    // The request is qualified with reset so it is low while reset is held
    // yet rises in the very first cycle after release.
    assign bus.IFU_ImemReq    = IFU_Reset_n && (state_q == ST_FETCH) && !fetch_block_s;
    assign bus.IFU_ImemAddr   = pc_q;
    assign bus.IFU_PC         = pc_q;
    assign bus.IFU_PCPlus4    = pc_plus4_s;
    assign bus.IFU_Instr      = instr_q;
    assign bus.IFU_InstrValid = (state_q == ST_READY);

    // Fetch FSM next-state, PC and instruction capture
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;
        case (state_q)
            ST_FETCH: begin
                if (fetch_block_s) begin
                    addr_err_d = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.IFU_ImemValid) begin
                    instr_d = bus.IFU_ImemRdata;
                    state_d = ST_READY;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_READY: begin
                if (bus.IFU_Next) begin
                    pc_d    = npc_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers
    always_ff @(posedge IFU_Clk or negedge IFU_Reset_n) begin
        if (!IFU_Reset_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_ifu.sv
`timescale 1ns/1ps
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ifu_if bus();

    ifu #(.RESET_PC(RST_PC), .IMEM_WORDS(1024)) dut (
        .IFU_Clk     (clk),
        .IFU_Reset_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_pc;

    typedef struct {
        logic [1:0]  ctrl;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] ra;
        logic [31:0] rdata;
        int          lat;
        int          hold;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference next PC from the architectural rules
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] ctrl,
                                             input logic [15:0] i16, input logic [25:0] i26,
                                             input logic [31:0] ra);
        logic [31:0] s;
        int off;
        s = pc + 32'd4;
        case (ctrl)
            2'd0: return s;
            2'd1: begin
                off = int'($signed(i16)) * 4;
                return s + 32'(off);
            end
            2'd2: return (s & 32'hF000_0000) | ({6'd0, i26} * 32'd4);
            default: return ra;
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        check($sformatf("%s req", tag),    32'(bus.IFU_ImemReq),    32'd0);
        check($sformatf("%s ivalid", tag), 32'(bus.IFU_InstrValid), 32'd0);
        check($sformatf("%s instr", tag),  bus.IFU_Instr,           32'd0);
        check($sformatf("%s err", tag),    32'(bus.IFU_AddrErr),    32'd0);
        check($sformatf("%s pc", tag),     bus.IFU_PC,              RST_PC);
        check($sformatf("%s pc+4", tag),   bus.IFU_PCPlus4,         RST_PC + 32'd4);
    endtask

    // One full instruction: called mid-cycle where a FETCH is expected.
    // Stray Next/Valid are driven where they must be ignored.
    task automatic run_instr(input string tag, input logic [1:0] ctrl, input logic [15:0] i16,
                             input logic [25:0] i26, input logic [31:0] ra, input logic [31:0] rdata,
                             input int lat, input int hold, input logic [31:0] exp_next);
        int waited = 0;
        while (bus.IFU_ImemReq !== 1'b1 && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s req-cycle", tag), 32'(waited), 32'd0);
        if (bus.IFU_ImemReq !== 1'b1) return;
        check($sformatf("%s addr", tag), bus.IFU_ImemAddr, model_pc);
        check($sformatf("%s pc+4", tag), bus.IFU_PCPlus4, model_pc + 32'd4);
        bus.IFU_Next      = 1'b1;
        bus.IFU_ImemValid = 1'b1;
        bus.IFU_ImemRdata = ~rdata;
        @(negedge clk);
        check($sformatf("%s wait req", tag), 32'(bus.IFU_ImemReq), 32'd0);
        check($sformatf("%s wait pc", tag), bus.IFU_PC, model_pc);
        for (int i = 0; i < lat; i++) begin
            bus.IFU_ImemValid = 1'b0;
            bus.IFU_Next      = 1'b1;
            @(negedge clk);
            check($sformatf("%s stall ivalid", tag), 32'(bus.IFU_InstrValid), 32'd0);
            check($sformatf("%s stall pc", tag), bus.IFU_PC, model_pc);
        end
        bus.IFU_Next      = 1'b0;
        bus.IFU_ImemValid = 1'b1;
        bus.IFU_ImemRdata = rdata;
        @(negedge clk);
        check($sformatf("%s ivalid", tag), 32'(bus.IFU_InstrValid), 32'd1);
        check($sformatf("%s instr", tag), bus.IFU_Instr, rdata);
        check($sformatf("%s err", tag), 32'(bus.IFU_AddrErr), 32'd0);
        bus.IFU_ImemRdata = ~rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("%s hold instr", tag), bus.IFU_Instr, rdata);
            check($sformatf("%s hold pc", tag), bus.IFU_PC, model_pc);
        end
        bus.IFU_ImemValid = 1'b0;
        bus.IFU_Ctrl      = ctrl;
        bus.IFU_Imm16     = i16;
        bus.IFU_Imm26     = i26;
        bus.IFU_RegAddr   = ra;
        bus.IFU_Next      = 1'b1;
        @(negedge clk);
        bus.IFU_Next      = 1'b0;
        bus.IFU_Ctrl      = 2'($urandom);
        bus.IFU_Imm16     = 16'($urandom);
        bus.IFU_Imm26     = 26'($urandom);
        bus.IFU_RegAddr   = $urandom;
        model_pc = exp_next;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.IFU_Ctrl = 2'd0;  bus.IFU_Imm16 = 16'd0; bus.IFU_Imm26 = 26'd0;
        bus.IFU_RegAddr = 32'd0; bus.IFU_Next = 1'b0;
        bus.IFU_ImemValid = 1'b0; bus.IFU_ImemRdata = 32'd0;

        tbl.push_back('{2'd0, 16'h0000, 26'h0000000, 32'h0, 32'h3C01_0001, 0, 0, 32'h0000_3004});
        tbl.push_back('{2'd1, 16'hFFFF, 26'h0000000, 32'h0, 32'h1111_0001, 1, 1, 32'h0000_3004});
        tbl.push_back('{2'd0, 16'h0000, 26'h0000000, 32'h0, 32'h2222_0002, 5, 0, 32'h0000_3008});
        tbl.push_back('{2'd2, 16'h0000, 26'h0000C10, 32'h0, 32'h3333_0003, 0, 2, 32'h0000_3040});
        tbl.push_back('{2'd3, 16'h0000, 26'h0000000, 32'h0000_3004, 32'h4444_0004, 2, 0, 32'h0000_3004});
        tbl.push_back('{2'd1, 16'h0003, 26'h0000000, 32'h0, 32'h5555_0005, 0, 0, 32'h0000_3014});
        tbl.push_back('{2'd3, 16'h0000, 26'h0000000, 32'h0000_3100, 32'h6666_0006, 1, 1, 32'h0000_3100});
`ifndef IFU_ADDR_CHECK_EN
        tbl.push_back('{2'd1, 16'h8000, 26'h0000000, 32'h0, 32'h7777_0007, 0, 0, 32'hFFFE_3104});
        tbl.push_back('{2'd2, 16'h0000, 26'h3FFFFFF, 32'h0, 32'h8888_0008, 0, 1, 32'hFFFF_FFFC});
        tbl.push_back('{2'd0, 16'h0000, 26'h0000000, 32'h0, 32'h9999_0009, 1, 0, 32'h0000_0000});
`endif

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        #1;
        model_pc = RST_PC;

        for (int i = 0; i < tbl.size(); i++)
            run_instr($sformatf("v%0d", i), tbl[i].ctrl, tbl[i].i16, tbl[i].i26, tbl[i].ra,
                      tbl[i].rdata, tbl[i].lat, tbl[i].hold, tbl[i].exp_next);

        // Reset in the middle of WAIT; stale response after release is dropped
        bus.IFU_ImemValid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midwait");
        @(negedge clk);
        rst_n = 1'b1;
        bus.IFU_ImemValid = 1'b1;
        bus.IFU_ImemRdata = 32'hDEAD_BEEF;
        #1;
        model_pc = RST_PC;
        run_instr("r035", 2'd0, 16'h0, 26'h0, 32'h0, 32'hA5A5_0001, 0, 0, RST_PC + 32'd4);

`ifndef IFU_ADDR_CHECK_EN
        // Randomized instruction stream against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  c;
            logic [15:0] a16;
            logic [25:0] a26;
            logic [31:0] r;
            c   = 2'($urandom_range(0, 3));
            a16 = 16'($urandom);
            a26 = 26'($urandom);
            r   = $urandom & 32'hFFFF_FFFC;
            run_instr($sformatf("rnd%0d", i), c, a16, a26, r, $urandom,
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                      ref_npc(model_pc, c, a16, a26, r));
        end
`endif

        // Misaligned jump-register target
        run_instr("jr3002", 2'd3, 16'h0, 26'h0, 32'h0000_3002, 32'hC0DE_0001, 0, 0, 32'h0000_3002);
`ifdef IFU_ADDR_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            check("bad req", 32'(bus.IFU_ImemReq), 32'd0);
            @(negedge clk);
            check("bad err", 32'(bus.IFU_AddrErr), 32'd1);
        end
`else
        check("bad req", 32'(bus.IFU_ImemReq), 32'd1);
        check("bad addr", bus.IFU_ImemAddr, 32'h0000_3002);
        check("bad err", 32'(bus.IFU_AddrErr), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-002 Parameter IMEM_WORDS, default 1024, SHALL be the instruction memory size in 32-bit words, used only by the range check.
REQ-003 IFU_Clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 IFU_Reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 IFU_Ctrl  in  2  SHALL be the resolved next-PC select: 0 = PC+4, 1 = branch, 2 = jump, 3 = jump-register.
REQ-006 IFU_Imm16  in  16  SHALL be the branch offset; IFU_Imm26  in  26  SHALL be the jump index.
REQ-007 IFU_RegAddr  in  32  SHALL be the jump-register target.
REQ-008 IFU_Next  in  1  SHALL be the consumer accept: the held instruction is taken and the PC advances using IFU_Ctrl.
REQ-009 IFU_ImemReq  out  1 and IFU_ImemAddr  out  32 SHALL form the fetch request; IFU_ImemValid  in  1 and IFU_ImemRdata  in  32 SHALL form the response.
REQ-010 IFU_Instr  out  32, IFU_InstrValid  out  1, IFU_PC  out  32, IFU_PCPlus4  out  32 SHALL present the fetched instruction and its address.
REQ-011 IFU_AddrErr  out  1 SHALL flag a bad fetch address (REQ-027).

Function
REQ-012 States FETCH, WAIT, READY SHALL be used; after reset the state SHALL be FETCH.
REQ-013 FETCH: IFU_ImemReq=1 and IFU_ImemAddr=PC for exactly one cycle, then go to WAIT.
REQ-014 WAIT: IFU_ImemReq=0; on IFU_ImemValid=1, capture IFU_ImemRdata into IFU_Instr and go to READY; otherwise stay.
REQ-015 IFU_ImemValid outside WAIT SHALL be ignored.
REQ-016 READY: IFU_InstrValid=1 and IFU_Instr held stable until IFU_Next=1 is sampled.
REQ-017 On IFU_Next=1 in READY, the PC SHALL load the next PC and the state SHALL go to FETCH; the minimum round trip is 3 cycles per instruction.
REQ-018 IFU_Next outside READY SHALL be ignored; the PC SHALL NOT change.
REQ-019 IFU_PCPlus4 SHALL equal PC+4 modulo 2^32, combinationally from the PC register.
REQ-020 Ctrl 0: next PC = PC+4.
REQ-021 Ctrl 1: next PC = PC+4 + {sign-extended Imm16, 2'b00}, 32-bit wrap-around.
REQ-022 Ctrl 2: next PC = {PC+4[31:28], Imm26, 2'b00}.
REQ-023 Ctrl 3: next PC = IFU_RegAddr, unmodified.
REQ-024 IFU_Ctrl, IFU_Imm16, IFU_Imm26 and IFU_RegAddr SHALL be sampled only in the cycle where IFU_Next=1 in READY.

Reset
REQ-025 Asserting IFU_Reset_n=0 at any time, including mid-WAIT, SHALL immediately force: PC=RESET_PC, state=FETCH, IFU_ImemReq=0, IFU_Instr=0, IFU_InstrValid=0, IFU_AddrErr=0.
REQ-026 A memory response arriving after reset deassertion for a pre-reset request SHALL be discarded; the first post-reset request SHALL be issued in the first cycle after release.

Configuration
REQ-027 With IFU_ADDR_CHECK_EN defined: in FETCH, if PC[1:0]!=0 or PC is outside [RESET_PC, RESET_PC+4*IMEM_WORDS), then IFU_ImemReq SHALL stay 0, IFU_AddrErr SHALL be set, and the state SHALL stay FETCH until reset (sticky).
REQ-028 Without IFU_ADDR_CHECK_EN: IFU_AddrErr SHALL be tied 0 and every address SHALL be fetched.

Structure
REQ-029 The shared package SHALL hold the IFU_Ctrl encodings (NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JR), the state encoding, and the default RESET_PC.
REQ-030 Next-PC computation SHALL be one combinational sub-module, ifu_npc; the state machine and registers SHALL stay in ifu.

Verification
REQ-031 Reset release, memory returns 32'h3C01_0001 one cycle after request -> ImemAddr=32'h0000_3000 on the first cycle; InstrValid=1 and Instr=32'h3C01_0001 on the third cycle.
REQ-032 PC=32'h0000_3004, Ctrl=1, Imm16=16'hFFFF, Next=1 -> next ImemAddr=32'h0000_3004 (self-loop); with Imm16=16'h0003 -> 32'h0000_3014.
REQ-033 PC=32'h0000_3008, Ctrl=2, Imm26=26'h0000C10 -> ImemAddr=32'h0000_3040; Ctrl=3, RegAddr=32'h0000_3100 -> ImemAddr=32'h0000_3100.
REQ-034 ImemValid held low for 5 cycles in WAIT, Next pulsed meanwhile -> InstrValid stays 0 and PC is unchanged; Instr is captured on the first Valid.
REQ-035 Reset asserted during WAIT, stale Valid arrives after release -> stale data not captured; the fresh fetch is at 32'h0000_3000.
REQ-036 IFU_ADDR_CHECK_EN defined, Ctrl=3, RegAddr=32'h0000_3002 -> AddrErr=1, ImemReq stays 0; without the macro -> ImemAddr=32'h0000_3002 and AddrErr=0.
